// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants and types for the register-file writeback path.
//   XLEN     : register data width
//   REG_AW   : register address width
//   NUM_REGS : number of architectural registers
//   REG_ZERO : index of the hard-wired zero register
//   grant_e  : which writeback requester owns the write port this cycle
package regfile_pkg;

  localparam int XLEN     = 64;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } grant_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that stops at MAX instead of wrapping.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (clears count)
//   inc : count up by one this cycle (ignored at MAX)
//   clr : synchronous clear, wins over inc
//   cnt : current count
module sat_counter #(
  parameter int           W   = 4,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Arbitrates the single register-file write port between the ALU and the
// load unit. One request is accepted per cycle and the write is issued from
// a register stage, so rd/rd_we/rd_in change one edge after the handshake.
//
// Default build: load (mem) has fixed priority; after MAX_WAIT consecutive
// losses the ALU is forced to win once so it cannot starve.
// With WB_ROUND_ROBIN_EN defined: a 1-bit last-winner pointer replaces the
// priority scheme and starvation counter; on a conflict the requester that
// did not win last is granted.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   alu_valid/ready/rd/data : ALU writeback request channel
//   mem_valid/ready/rd/data : load writeback request channel
//   rd, rd_we, rd_in     : registered register-file write port
//   conflict_cnt         : saturating count of cycles with both requests valid
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN     = regfile_pkg::XLEN,
  parameter int REG_AW   = regfile_pkg::REG_AW,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  output logic [REG_AW-1:0] rd,
  output logic              rd_we,
  output logic [XLEN-1:0]   rd_in,
  output logic [CNT_W-1:0]  conflict_cnt
);

  grant_e grant;
  logic   alu_xfer;
  logic   mem_xfer;

`ifdef WB_ROUND_ROBIN_EN
  // 1 = ALU won the most recent transfer; reset value makes mem win the
  // first conflict.
  logic last_alu;

  always_comb begin
    grant = GNT_NONE;
    if (alu_valid && mem_valid) begin
      grant = last_alu ? GNT_MEM : GNT_ALU;
    end else if (mem_valid) begin
      grant = GNT_MEM;
    end else if (alu_valid) begin
      grant = GNT_ALU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_alu <= 1'b1;
    end else if (alu_xfer) begin
      last_alu <= 1'b1;
    end else if (mem_xfer) begin
      last_alu <= 1'b0;
    end
  end
`else
  // MAX_WAIT is limited to 1..15, so 4 bits always suffice.
  localparam int STARVE_W = 4;

  logic [STARVE_W-1:0] starve_cnt;
  logic                force_alu;

  assign force_alu = alu_valid && (starve_cnt == STARVE_W'(MAX_WAIT));

  always_comb begin
    grant = GNT_NONE;
    if (mem_valid && !force_alu) begin
      grant = GNT_MEM;
    end else if (alu_valid) begin
      grant = GNT_ALU;
    end
  end

  // Counts consecutive cycles the ALU was waiting and lost; any cycle the
  // ALU is idle or wins restarts the run.
  sat_counter #(
    .W   (STARVE_W),
    .MAX (STARVE_W'(MAX_WAIT))
  ) u_starve_cnt (
    .clk (clk),
    .rst (rst),
    .inc (alu_valid && !alu_ready),
    .clr (alu_xfer || !alu_valid),
    .cnt (starve_cnt)
  );
`endif

  // Gating with rst keeps both requesters un-acknowledged during reset.
  assign alu_ready = !rst && (grant == GNT_ALU);
  assign mem_ready = !rst && (grant == GNT_MEM);
  assign alu_xfer  = alu_valid && alu_ready;
  assign mem_xfer  = mem_valid && mem_ready;

  sat_counter #(
    .W   (CNT_W),
    .MAX ({CNT_W{1'b1}})
  ) u_conflict_cnt (
    .clk (clk),
    .rst (rst),
    .inc (alu_valid && mem_valid),
    .clr (1'b0),
    .cnt (conflict_cnt)
  );

  // Writes to the zero register are accepted but never enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd    <= '0;
      rd_we <= 1'b0;
      rd_in <= '0;
    end else if (mem_xfer) begin
      rd    <= mem_rd;
      rd_in <= mem_data;
      rd_we <= (mem_rd != REG_AW'(REG_ZERO));
    end else if (alu_xfer) begin
      rd    <= alu_rd;
      rd_in <= alu_data;
      rd_we <= (alu_rd != REG_AW'(REG_ZERO));
    end else begin
      rd_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              alu_valid = 1'b0;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd = '0;
  logic [XLEN-1:0]   alu_data = '0;
  logic              mem_valid = 1'b0;
  logic              mem_ready;
  logic [REG_AW-1:0] mem_rd = '0;
  logic [XLEN-1:0]   mem_data = '0;
  logic [REG_AW-1:0] rd;
  logic              rd_we;
  logic [XLEN-1:0]   rd_in;
  logic [CNT_W-1:0]  conflict_cnt;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(
    .XLEN     (XLEN),
    .REG_AW   (REG_AW),
    .MAX_WAIT (4),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .rd           (rd),
    .rd_we        (rd_we),
    .rd_in        (rd_in),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  // Register file consumer; it shares the synchronous reset, so a write
  // presented on a reset edge is not committed.
  logic [XLEN-1:0] regs [32];
  initial for (int i = 0; i < 32; i++) regs[i] = '0;
  always @(posedge clk) if (rd_we && !rst) regs[rd] <= rd_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic              av;
    logic [REG_AW-1:0] ard;
    logic [XLEN-1:0]   adat;
    logic              mv;
    logic [REG_AW-1:0] mrd;
    logic [XLEN-1:0]   mdat;
    logic              e_ar;
    logic              e_mr;
    logic              e_we;
    logic [REG_AW-1:0] e_rd;
    logic [XLEN-1:0]   e_in;
  } vec_t;

  vec_t vecs [7];
  logic e_alu_win [6];

  initial begin
    vecs[0] = '{1'b1, 5'd5,  64'h1234,             1'b0, 5'd0,  64'h0,    1'b1, 1'b0, 1'b1, 5'd5,  64'h1234};
    vecs[1] = '{1'b0, 5'd0,  64'h0,                1'b0, 5'd0,  64'h0,    1'b0, 1'b0, 1'b0, 5'd5,  64'h1234};
    vecs[2] = '{1'b0, 5'd0,  64'h0,                1'b1, 5'd0,  64'hFF,   1'b0, 1'b1, 1'b0, 5'd0,  64'hFF};
    vecs[3] = '{1'b0, 5'd0,  64'h0,                1'b1, 5'd31, 64'hDEAD, 1'b0, 1'b1, 1'b1, 5'd31, 64'hDEAD};
    vecs[4] = '{1'b1, 5'd0,  64'h77,               1'b0, 5'd0,  64'h0,    1'b1, 1'b0, 1'b0, 5'd0,  64'h77};
    vecs[5] = '{1'b0, 5'd0,  64'h0,                1'b0, 5'd0,  64'h0,    1'b0, 1'b0, 1'b0, 5'd0,  64'h77};
    vecs[6] = '{1'b1, 5'd7,  64'h0123456789ABCDEF, 1'b0, 5'd0,  64'h0,    1'b1, 1'b0, 1'b1, 5'd7,  64'h0123456789ABCDEF};

`ifdef WB_ROUND_ROBIN_EN
    for (int i = 0; i < 6; i++) e_alu_win[i] = (i % 2) == 1;
`else
    for (int i = 0; i < 6; i++) e_alu_win[i] = (i == 4);
`endif

    // Reset held 3 cycles with both requesters valid.
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hA;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 64'hB;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_alu_ready", 64'(alu_ready), 64'd0);
      chk("rst_mem_ready", 64'(mem_ready), 64'd0);
      tick();
      chk("rst_rd_we", 64'(rd_we), 64'd0);
      chk("rst_conflict", 64'(conflict_cnt), 64'd0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_mem_ready", 64'(mem_ready), 64'd1);
    chk("post_rst_alu_ready", 64'(alu_ready), 64'd0);
    tick();
    chk("post_rst_rd", 64'(rd), 64'd4);
    chk("post_rst_rd_we", 64'(rd_we), 64'd1);
    chk("post_rst_rd_in", rd_in, 64'hB);
    chk("post_rst_conflict", 64'(conflict_cnt), 64'd1);

    // Single-requester vectors.
    for (int i = 0; i < 7; i++) begin
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adat;
      mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_data = vecs[i].mdat;
      #1;
      chk($sformatf("vec%0d_alu_ready", i), 64'(alu_ready), 64'(vecs[i].e_ar));
      chk($sformatf("vec%0d_mem_ready", i), 64'(mem_ready), 64'(vecs[i].e_mr));
      tick();
      chk($sformatf("vec%0d_rd_we", i), 64'(rd_we), 64'(vecs[i].e_we));
      chk($sformatf("vec%0d_rd", i), 64'(rd), 64'(vecs[i].e_rd));
      chk($sformatf("vec%0d_rd_in", i), rd_in, vecs[i].e_in);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick();
    tick();
    chk("reg5", regs[5], 64'h1234);
    chk("reg0", regs[0], 64'h0);
    chk("reg31", regs[31], 64'hDEAD);
    chk("reg7", regs[7], 64'h0123456789ABCDEF);
    chk("conflict_hold", 64'(conflict_cnt), 64'd1);

    // Clear counters, then continuous conflict on the same destination.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 64'hAAAA;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 64'hBBBB;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("conf%0d_alu_ready", i), 64'(alu_ready), 64'(e_alu_win[i]));
      chk($sformatf("conf%0d_mem_ready", i), 64'(mem_ready), 64'(!e_alu_win[i]));
      tick();
      chk($sformatf("conf%0d_rd_we", i), 64'(rd_we), 64'd1);
      chk($sformatf("conf%0d_rd_in", i), rd_in, e_alu_win[i] ? 64'hAAAA : 64'hBBBB);
      chk($sformatf("conf%0d_cnt", i), 64'(conflict_cnt), 64'(i + 1));
    end

    // Saturation of the 4-bit conflict counter: 20 conflict cycles total.
    for (int i = 6; i < 20; i++) begin
      tick();
      if (i == 14) chk("conflict_at_15", 64'(conflict_cnt), 64'd15);
    end
    chk("conflict_sat", 64'(conflict_cnt), 64'd15);

    // Reset right after an ALU handshake drops the pending write.
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
    mem_valid = 1'b0;
    #1;
    chk("abort_alu_ready", 64'(alu_ready), 64'd1);
    tick();
    chk("abort_rd_we_pre", 64'(rd_we), 64'd1);
    alu_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_ready_in_rst", 64'(alu_ready), 64'd0);
    tick();
    chk("abort_rd_we", 64'(rd_we), 64'd0);
    chk("abort_rd", 64'(rd), 64'd0);
    chk("abort_rd_in", rd_in, 64'd0);
    chk("abort_conflict", 64'(conflict_cnt), 64'd0);
    rst = 1'b0;
    tick();
    chk("abort_reg9", regs[9], 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (rd / rd_we / rd_in) between two writeback requesters: ALU result and memory load.
- Each requester uses a valid/ready handshake; one write is granted per cycle and issued through a registered output stage.
- Mem has fixed priority; a starvation guard guarantees ALU progress.
- Also counts contention cycles for performance debug.

Parameters:
XLEN, 64, data width of register file write port
REG_AW, 5, register address width (32 registers)
MAX_WAIT, 4, consecutive ALU losses before ALU is forced to win (range 1..15)
CNT_W, 16, width of conflict counter

Ports:
clk  in  1  rising-edge clock, shared with register file
rst  in  1  synchronous, active-high reset
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request accepted this cycle
alu_rd  in  REG_AW  ALU destination register
alu_data  in  XLEN  ALU writeback data
mem_valid  in  1  load writeback request
mem_ready  out  1  load request accepted this cycle
mem_rd  in  REG_AW  load destination register
mem_data  in  XLEN  load writeback data
rd  out  REG_AW  to register file write address
rd_we  out  1  to register file write enable
rd_in  out  XLEN  to register file write data
conflict_cnt  out  CNT_W  cycles with both requesters valid

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- Reset values:
  - rd=0, rd_we=0, rd_in=0, conflict_cnt=0, internal starve_cnt=0.
  - alu_ready=mem_ready=0 while rst=1.
- Grant (combinational, computed from valids and starve_cnt only):
  - force_alu = alu_valid && starve_cnt==MAX_WAIT.
  - If mem_valid && !force_alu, grant mem.
  - Otherwise, if alu_valid, grant alu.
  - Otherwise, no grant.
- Handshake rules:
  - x_ready = grant==x. Transfer occurs when x_valid && x_ready.
  - Requesters must hold valid/rd/data stable until accepted.
  - ready never asserts without the matching valid.
- Output stage (registered, 1-cycle latency):
  - On a transfer: rd<=x_rd, rd_in<=x_data, rd_we<=(x_rd!=0).
  - With no transfer: rd_we<=0; rd and rd_in hold their previous values.
  - The register file commits on the following edge, so new data is readable 2 edges after the handshake edge.
- x0 writes are accepted (ready=1) but discarded (rd_we stays 0).
- starve_cnt:
  - +1 when alu_valid && !alu_ready, saturating at MAX_WAIT.
  - Cleared to 0 when ALU transfers or alu_valid=0.
- conflict_cnt: +1 every cycle with alu_valid && mem_valid; saturates at all-ones (no wrap).
- Same rd from both requesters: handled as two independent writes in grant order; no coalescing.
- Reset mid-operation: pending registered write is dropped (rd_we=0 next cycle); counters cleared; no requester is acknowledged during reset.

Optional Feature:
- Macro: WB_ROUND_ROBIN_EN.
- Defined:
  - Fixed priority and starve_cnt are replaced by a 1-bit last-winner pointer.
  - On conflict, the requester that did not win last is granted.
  - Pointer resets to "ALU won last", so mem wins the first conflict.
  - Pointer updates only on transfer.
- Undefined: fixed mem priority with the MAX_WAIT starvation guard, as above.
- conflict_cnt behaves identically in both builds.

Decomposition:
- Package regfile_pkg:
  - XLEN, REG_AW, NUM_REGS=32, REG_ZERO=0.
  - Grant enum {GNT_NONE, GNT_ALU, GNT_MEM}.
- One sub-module: sat_counter (parameterised width, inc, clr, saturating), instantiated for starve_cnt and conflict_cnt.

Test Plan:
- Reset: hold rst 3 cycles with both valid -> rd_we=0, both ready=0, conflict_cnt=0; after release, mem granted first cycle.
- Single ALU write alu_rd=5, alu_data=0x1234 -> alu_ready=1 same cycle; next cycle rd=5, rd_we=1, rd_in=0x1234; register file out1 reads 0x1234 one cycle later with rs1=5.
- Continuous conflict, MAX_WAIT=4 -> mem wins 4 cycles, ALU wins the 5th, then mem resumes; conflict_cnt=5 after 5 cycles.
- Write to x0 from mem (mem_rd=0, data=0xFF) -> mem_ready=1, rd_we stays 0; register 0 still reads 0.
- conflict_cnt saturation with CNT_W=4: 20 conflict cycles -> conflict_cnt=15.
- rst asserted the cycle after an ALU handshake -> rd_we=0 next cycle, write not committed; with WB_ROUND_ROBIN_EN, conflict sequence alternates mem, alu, mem, alu.
